dice_roll_scheduler: RTL
========================

DICE_ROLL_SCHEDULER -- requirements
Module: dice_roll_scheduler

Interface
REQ-001 The module SHALL have parameter NREQ, default 4, number of requesters; only the value 4 is required to be supported.
REQ-002 The module SHALL have parameter LAT, default 1, the number of idle cycles between the dr_roll pulse and sampling dr_rolled_number (range 1..7).
REQ-003 The module SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The module SHALL have port req  input  4  per-requester level request, held until its ack.
REQ-006 The module SHALL have port req_die  input  8  die select for requester k, 2 bits at [2k+1:2k]: 00=d4, 01=d6, 10=d8, 11=d20.
REQ-007 The module SHALL have port req_count  input  12  number of dice for requester k, 3 bits at [3k+2:3k], where 0 is treated as 1.
REQ-008 The module SHALL have port ack  output  4  one-hot, one-cycle pulse when a request is accepted.
REQ-009 The module SHALL have port dr_die_select  output  2  die select driven to the shared dice roller.
REQ-010 The module SHALL have port dr_roll  output  1  one-cycle roll strobe to the dice roller.
REQ-011 The module SHALL have port dr_rolled_number  input  8  result from the dice roller.
REQ-012 The module SHALL have port rsp_valid  output  1  one-cycle pulse marking a completed response.
REQ-013 The module SHALL have port rsp_id  output  2  index of the served requester.
REQ-014 The module SHALL have port rsp_sum  output  8  sum of all dice rolled for the request.
REQ-015 The module SHALL have port rsp_err  output  1  at least one roll was out of range.
REQ-016 The module SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ROLL, WAIT, CAPTURE and RESP.
REQ-018 In IDLE with any req bit set, the module SHALL grant round-robin: search starts at last_grant+1 mod 4 and wraps.
REQ-019 On grant, the module SHALL pulse ack[k], latch the die, the count (0→1) and id, clear the accumulator and error, and go to ROLL on the next cycle.
REQ-020 In ROLL, the module SHALL assert dr_roll for exactly one cycle, with dr_die_select equal to the latched die, then go to WAIT.
REQ-021 dr_die_select SHALL hold the latched die from ROLL through CAPTURE, and SHALL be 00 in IDLE.
REQ-022 WAIT SHALL last exactly LAT cycles, counted by an internal counter, then go to CAPTURE.
REQ-023 In CAPTURE, the module SHALL sample dr_rolled_number; if it is in the range 1..sides (4/6/8/20), it SHALL be added to the accumulator, otherwise rsp_err SHALL be set and 0 added.
REQ-024 In CAPTURE, the remaining count SHALL decrement; if the new value is nonzero the FSM goes to ROLL, otherwise to RESP.
REQ-025 The accumulator SHALL be 8 bits and SHALL NOT overflow (maximum 7×20=140).
REQ-026 In RESP, the module SHALL hold rsp_valid=1 for one cycle with rsp_id, rsp_sum and rsp_err, and SHALL update last_grant to the served id.
REQ-027 The FSM SHALL then return to IDLE, so there is at least one IDLE cycle between responses.
REQ-028 rsp_sum, rsp_id and rsp_err SHALL hold their values until the next RESP.
REQ-029 A req that deasserts after its ack SHALL NOT affect the request in progress.
REQ-030 A req that is still asserted in IDLE after being served SHALL be treated as a new request.
REQ-031 Requests arriving while busy SHALL be ignored until IDLE, with no loss as long as req is held.
REQ-032 Only one ack bit SHALL be high per cycle, even when multiple requests arrive simultaneously.
REQ-033 Total latency from ack to rsp_valid SHALL be n×(LAT+2)+1 cycles, where n is the effective count.

Reset
REQ-034 On rst_n=0, the module SHALL asynchronously enter IDLE and clear ack, dr_roll, dr_die_select, rsp_valid, rsp_id, rsp_sum, rsp_err and busy to 0.
REQ-035 Reset SHALL set last_grant=3, so requester 0 has first priority.
REQ-036 A reset during ROLL, WAIT or CAPTURE SHALL abandon the request with no rsp_valid; a still-held req SHALL be re-arbitrated after release.
REQ-037 Reset release SHALL be synchronous to clk at the flop level; the first grant SHALL be possible on the first edge after rst_n rises.

Verification
REQ-038 A bench SHALL cover: req=0001, die=d6, count=3, roller model returns 2,5,6, LAT=1 -> ack[0] one cycle after the request is seen; rsp_valid 10 cycles later; rsp_id=0, sum=13, err=0.
REQ-039 A bench SHALL cover: req=1111 held, all count=1 -> acks in order 0,1,2,3,0; exactly one ack per response; none starved.
REQ-040 A bench SHALL cover: die=d20, count=7, model returns 20 each time -> sum=140, err=0.
REQ-041 A bench SHALL cover: die=d4, model returns 0 then 5 then 3 (count=3) -> err=1, sum=3.
REQ-042 A bench SHALL cover: req_count=0, die=d8 -> exactly one dr_roll pulse; the sampled value is returned.
REQ-043 A bench SHALL cover: rst_n pulsed low during WAIT -> outputs 0 immediately, no rsp_valid; after release the still-held req is re-acked, with requester 0 winning when 0 and 2 are both requesting.

Source files
------------

// File: rtl/dice_roll_scheduler.sv
// Round-robin scheduler that shares one dice roller between NREQ requesters.
// Each accepted request rolls its die count times and returns the sum plus an
// out-of-range flag.
module dice_roll_scheduler #(
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   req_die,
    input  logic [3*NREQ-1:0]   req_count,
    output logic [NREQ-1:0]     ack,
    output logic [1:0]          dr_die_select,
    output logic                dr_roll,
    input  logic [7:0]          dr_rolled_number,
    output logic                rsp_valid,
    output logic [1:0]          rsp_id,
    output logic [7:0]          rsp_sum,
    output logic                rsp_err,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROLL,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  last_grant;
    logic [1:0]  cand;
    logic        grant_found;
    logic [1:0]  grant_idx;
    logic [1:0]  sel_die;
    logic [2:0]  sel_count;

    logic [1:0]  die_q;
    logic [2:0]  cnt_q;
    logic [1:0]  id_q;
    logic [7:0]  acc_q;
    logic        err_q;
    logic [2:0]  wait_cnt;

    logic        roll_ok;
    logic [7:0]  roll_add;
    logic [7:0]  acc_sum;

    // Number of faces for each die encoding.
    function automatic logic [7:0] die_sides(input logic [1:0] d);
        case (d)
            2'b00:   die_sides = 8'd4;
            2'b01:   die_sides = 8'd6;
            2'b10:   die_sides = 8'd8;
            default: die_sides = 8'd20;
        endcase
    endfunction

    // Round-robin search starting one past the last served requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = last_grant + 2'(i);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Die and count fields of the winning requester.
    always_comb begin
        sel_die   = req_die[2*grant_idx +: 2];
        sel_count = req_count[3*grant_idx +: 3];
    end

    // Range check of the sampled roll; out-of-range rolls contribute nothing.
    always_comb begin
        roll_ok  = (dr_rolled_number != 8'd0) && (dr_rolled_number <= die_sides(die_q));
        roll_add = roll_ok ? dr_rolled_number : 8'd0;
        acc_sum  = acc_q + roll_add;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode; the ack cycle is spent in IDLE before ROLL.
    always_comb begin
        state_nxt     = state;
        dr_roll       = 1'b0;
        dr_die_select = 2'b00;
        rsp_valid     = 1'b0;
        busy          = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (ack != '0) begin
                    state_nxt = S_ROLL;
                end
            end
            S_ROLL: begin
                dr_roll       = 1'b1;
                dr_die_select = die_q;
                state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                dr_die_select = die_q;
                if (wait_cnt == 3'(LAT - 1)) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                dr_die_select = die_q;
                state_nxt     = (cnt_q == 3'd1) ? S_RESP : S_ROLL;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant latching, wait counting, accumulation and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack        <= '0;
            die_q      <= 2'd0;
            cnt_q      <= 3'd0;
            id_q       <= 2'd0;
            acc_q      <= 8'd0;
            err_q      <= 1'b0;
            wait_cnt   <= 3'd0;
            last_grant <= 2'd3;
            rsp_id     <= 2'd0;
            rsp_sum    <= 8'd0;
            rsp_err    <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                S_IDLE: begin
                    if (ack == '0 && grant_found) begin
                        ack[grant_idx] <= 1'b1;
                        die_q          <= sel_die;
                        cnt_q          <= (sel_count == 3'd0) ? 3'd1 : sel_count;
                        id_q           <= grant_idx;
                        acc_q          <= 8'd0;
                        err_q          <= 1'b0;
                    end
                end
                S_ROLL: begin
                    wait_cnt <= 3'd0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 3'd1;
                end
                S_CAPTURE: begin
                    acc_q <= acc_sum;
                    err_q <= err_q | ~roll_ok;
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        rsp_id  <= id_q;
                        rsp_sum <= acc_sum;
                        rsp_err <= err_q | ~roll_ok;
                    end
                end
                S_RESP: begin
                    last_grant <= id_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
